// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and constants for the two-road phase sequencer.
// Contents: phase encoding (3 bits), LED lamp patterns, blank digit value,
// lamp decode helper and a duration range check.
// Macro PED_WALK_EN adds the WALK phase encoding.
package traffic_phase_ctrl_pkg;

  localparam int unsigned TIMER_W  = 4;
  localparam int unsigned LED_W    = 6;
  localparam int unsigned DUR_MAX  = 15;

  typedef enum logic [2:0] {
    PH_A_GRN = 3'd0,
    PH_A_YEL = 3'd1,
    PH_AR_AB = 3'd2,
    PH_B_GRN = 3'd3,
    PH_B_YEL = 3'd4,
    PH_AR_BA = 3'd5
`ifdef PED_WALK_EN
    , PH_WALK = 3'd6
`endif
  } phase_e;

  // LED order: {B_red, B_yel, B_grn, A_red, A_yel, A_grn}
  localparam logic [LED_W-1:0] LED_A_GRN  = 6'b100_001;
  localparam logic [LED_W-1:0] LED_A_YEL  = 6'b100_010;
  localparam logic [LED_W-1:0] LED_B_GRN  = 6'b001_100;
  localparam logic [LED_W-1:0] LED_B_YEL  = 6'b010_100;
  localparam logic [LED_W-1:0] LED_ALLRED = 6'b100_100;

  localparam logic [TIMER_W-1:0] BLANK_DIGIT = 4'hF;

  typedef struct packed {
    logic [LED_W-1:0]   led;
    logic [TIMER_W-1:0] q;
    logic [TIMER_W-1:0] r;
  } lamp_t;

  // Lamps and digits for a phase; the road that is not red shows the timer.
  function automatic lamp_t decode_lamps(phase_e ph, logic [TIMER_W-1:0] timer);
    lamp_t l;
    l.led = LED_ALLRED;
    l.q   = BLANK_DIGIT;
    l.r   = BLANK_DIGIT;
    case (ph)
      PH_A_GRN: begin l.led = LED_A_GRN; l.q = timer; end
      PH_A_YEL: begin l.led = LED_A_YEL; l.q = timer; end
      PH_B_GRN: begin l.led = LED_B_GRN; l.r = timer; end
      PH_B_YEL: begin l.led = LED_B_YEL; l.r = timer; end
      default:  l.led = LED_ALLRED;
    endcase
    return l;
  endfunction

  function automatic bit dur_ok(int unsigned d);
    return (d >= 1) && (d <= DUR_MAX);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Intersection I/O bundle between the phase sequencer and its environment.
// car_b : side-road vehicle sensor (synchronised)
// q, r  : road A / road B countdown digits, 4'hF = blank
// LED   : {B_red,B_yel,B_grn,A_red,A_yel,A_grn}
// ped_req, walk : pedestrian button and walk lamp, only with PED_WALK_EN.
interface traffic_phase_ctrl_if;
  logic       car_b;
  logic [3:0] q;
  logic [3:0] r;
  logic [5:0] LED;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;
`endif

  modport master (
    output car_b,
`ifdef PED_WALK_EN
    output ped_req,
    input  walk,
`endif
    input  q, r, LED
  );

  modport slave (
    input  car_b,
`ifdef PED_WALK_EN
    input  ped_req,
    output walk,
`endif
    output q, r, LED
  );
endinterface

// File: rtl/traffic_phase_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// Ports: clk, resetSW (sync, active-high), tick (high while count == TICK_DIV-1).
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic resetSW,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (resetSW)           r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                   r_cnt <= r_cnt + CNT_W'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer (A = main road, B = side road).
// Steps GREEN/YELLOW/ALL-RED on the tick, resting in A green until a side-road
// car is pending. Lamps and digits are registered from the next-state decode,
// so they change on the same edge as the phase with no extra latency.
// Ports: clk, resetSW (sync, active-high), bus (traffic_phase_ctrl_if.slave:
// car_b in; q, r, LED out; ped_req in / walk out with PED_WALK_EN).
// Macro PED_WALK_EN: adds pedestrian latch and WALK phase after AR_BA.
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned GREEN_A  = 10,
  parameter int unsigned GREEN_B  = 6,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned WALK_T   = 5
) (
  input  logic                 clk,
  input  logic                 resetSW,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int unsigned TICK_MAX = 1 << 27;

  // Elaboration-time parameter range checks.
  if (!dur_ok(GREEN_A) || !dur_ok(GREEN_B) || !dur_ok(YELLOW_T) ||
      !dur_ok(ALLRED_T) || !dur_ok(WALK_T)) begin : g_bad_dur
    $error("traffic_phase_ctrl: phase durations must be within 1..15");
  end
  if (TICK_DIV < 2 || TICK_DIV > TICK_MAX) begin : g_bad_div
    $error("traffic_phase_ctrl: TICK_DIV must be within 2..2^27");
  end

  localparam logic [TIMER_W-1:0] LD_GA = TIMER_W'(GREEN_A - 1);
  localparam logic [TIMER_W-1:0] LD_GB = TIMER_W'(GREEN_B - 1);
  localparam logic [TIMER_W-1:0] LD_Y  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] LD_AR = TIMER_W'(ALLRED_T - 1);
`ifdef PED_WALK_EN
  localparam logic [TIMER_W-1:0] LD_W  = TIMER_W'(WALK_T - 1);
`endif

  logic               w_tick;
  logic               w_pend_b;
  logic               w_leave_a;
  logic               w_enter_bgrn;
  phase_e             w_nxt_phase;
  logic [TIMER_W-1:0] w_nxt_timer;
  lamp_t              w_lamps;

  phase_e             r_phase;
  logic [TIMER_W-1:0] r_timer;
  logic               r_car_b_lat;
  lamp_t              r_lamps;
`ifdef PED_WALK_EN
  logic               w_pend_p;
  logic               w_enter_walk;
  logic               r_ped_lat;
  logic               r_walk;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .resetSW (resetSW),
    .tick    (w_tick)
  );

  // Next phase/timer; a request in the expiry cycle itself counts as pending.
  always_comb begin
    w_nxt_phase = r_phase;
    w_nxt_timer = r_timer;
    w_pend_b    = r_car_b_lat | bus.car_b;
`ifdef PED_WALK_EN
    w_pend_p    = r_ped_lat | bus.ped_req;
    w_leave_a   = w_pend_b | w_pend_p;
`else
    w_leave_a   = w_pend_b;
`endif
    if (w_tick) begin
      if (r_timer == '0) begin
        case (r_phase)
          PH_A_GRN: begin
            if (w_leave_a) begin
              w_nxt_phase = PH_A_YEL;
              w_nxt_timer = LD_Y;
            end else begin
              w_nxt_timer = LD_GA;
            end
          end
          PH_A_YEL: begin w_nxt_phase = PH_AR_AB; w_nxt_timer = LD_AR; end
          PH_AR_AB: begin w_nxt_phase = PH_B_GRN; w_nxt_timer = LD_GB; end
          PH_B_GRN: begin w_nxt_phase = PH_B_YEL; w_nxt_timer = LD_Y;  end
          PH_B_YEL: begin w_nxt_phase = PH_AR_BA; w_nxt_timer = LD_AR; end
`ifdef PED_WALK_EN
          PH_AR_BA: begin
            if (w_pend_p) begin
              w_nxt_phase = PH_WALK;
              w_nxt_timer = LD_W;
            end else begin
              w_nxt_phase = PH_A_GRN;
              w_nxt_timer = LD_GA;
            end
          end
`endif
          default:  begin w_nxt_phase = PH_A_GRN; w_nxt_timer = LD_GA; end
        endcase
      end else begin
        w_nxt_timer = r_timer - TIMER_W'(1);
      end
    end
    w_enter_bgrn = (w_nxt_phase == PH_B_GRN) && (r_phase != PH_B_GRN);
`ifdef PED_WALK_EN
    w_enter_walk = (w_nxt_phase == PH_WALK) && (r_phase != PH_WALK);
`endif
    w_lamps = decode_lamps(w_nxt_phase, w_nxt_timer);
  end

  // Phase register, request latches and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (resetSW) begin
      r_phase     <= PH_A_GRN;
      r_timer     <= LD_GA;
      r_car_b_lat <= 1'b0;
      r_lamps     <= decode_lamps(PH_A_GRN, LD_GA);
`ifdef PED_WALK_EN
      r_ped_lat   <= 1'b0;
      r_walk      <= 1'b0;
`endif
    end else begin
      r_phase <= w_nxt_phase;
      r_timer <= w_nxt_timer;
      r_lamps <= w_lamps;
      // Cars seen during B green are being served, so they are not latched.
      if (w_enter_bgrn)                         r_car_b_lat <= 1'b0;
      else if (bus.car_b && r_phase != PH_B_GRN) r_car_b_lat <= 1'b1;
`ifdef PED_WALK_EN
      if (w_enter_walk)     r_ped_lat <= 1'b0;
      else if (bus.ped_req) r_ped_lat <= 1'b1;
      r_walk <= (w_nxt_phase == PH_WALK);
`endif
    end
  end

  assign bus.LED = r_lamps.led;
  assign bus.q   = r_lamps.q;
  assign bus.r   = r_lamps.r;
`ifdef PED_WALK_EN
  assign bus.walk = r_walk;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: random and directed scenarios checked against
// a tick-level behavioural model (phase index + remaining ticks).
module tb_traffic_phase_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned GA = 5;
  localparam int unsigned GB = 3;
  localparam int unsigned YT = 2;
  localparam int unsigned AR = 1;
  localparam int unsigned WT = 5;

  logic clk = 1'b0;
  logic resetSW;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if bif();

  traffic_phase_ctrl #(
    .TICK_DIV(TD), .GREEN_A(GA), .GREEN_B(GB),
    .YELLOW_T(YT), .ALLRED_T(AR), .WALK_T(WT)
  ) dut (
    .clk     (clk),
    .resetSW (resetSW),
    .bus     (bif)
  );

  logic w_walk;
`ifdef PED_WALK_EN
  assign w_walk = bif.walk;
`else
  assign w_walk = 1'b0;
`endif
  logic [14:0] w_act;
  assign w_act = {bif.LED, bif.q, bif.r, w_walk};

  int errors = 0;
  int checks = 0;

  // Model: phases 0 A_GRN,1 A_YEL,2 AR_AB,3 B_GRN,4 B_YEL,5 AR_BA,6 WALK
  int DUR [7] = '{GA, YT, AR, GB, YT, AR, WT};
  logic [5:0] LEDS [7] = '{6'b100001, 6'b100010, 6'b100100, 6'b001100,
                           6'b010100, 6'b100100, 6'b100100};
  int m_div, m_ph, m_left;
  bit m_latb, m_latp;

  function automatic logic [14:0] exp_vec();
    logic [3:0] q, r;
    q = (m_ph == 0 || m_ph == 1) ? 4'(m_left) : 4'hF;
    r = (m_ph == 3 || m_ph == 4) ? 4'(m_left) : 4'hF;
    return {LEDS[m_ph], q, r, (m_ph == 6)};
  endfunction

  task automatic set_ped(input bit v);
`ifdef PED_WALK_EN
    bif.ped_req = v;
`else
    if (v) m_latp = m_latp;
`endif
  endtask

  // Advance one clock and move the model with the inputs seen at that edge.
  task automatic step();
    bit rs, cb, pr, tk;
    int nph, nleft;
    rs = resetSW;
    cb = bif.car_b;
`ifdef PED_WALK_EN
    pr = bif.ped_req;
`else
    pr = 1'b0;
`endif
    @(posedge clk);
    if (rs) begin
      m_div = 0; m_ph = 0; m_left = GA - 1; m_latb = 0; m_latp = 0;
    end else begin
      tk = (m_div == TD - 1);
      m_div = tk ? 0 : m_div + 1;
      nph = m_ph;
      nleft = m_left;
      if (tk) begin
        if (m_left == 0) begin
          case (m_ph)
            0: nph = (m_latb || cb || m_latp || pr) ? 1 : 0;
            5: nph = (m_latp || pr) ? 6 : 0;
            6: nph = 0;
            default: nph = m_ph + 1;
          endcase
          nleft = DUR[nph] - 1;
        end else begin
          nleft = m_left - 1;
        end
      end
      if (nph == 3 && m_ph != 3) m_latb = 0;
      else if (cb && m_ph != 3)  m_latb = 1;
      if (nph == 6 && m_ph != 6) m_latp = 0;
      else if (pr)               m_latp = 1;
      m_ph = nph;
      m_left = nleft;
    end
    #1;
  endtask

  task automatic test_reset();
    resetSW = 1'b1;
    bif.car_b = 1'b0;
    set_ped(1'b0);
    step();
    step();
    resetSW = 1'b0;
    checks++; if (bif.LED !== 6'b100001) begin errors++; $display("FAIL reset_led got=%b want=100001", bif.LED); end
    checks++; if (bif.q !== 4'd4) begin errors++; $display("FAIL reset_q got=%h want=4", bif.q); end
    checks++; if (bif.r !== 4'hF) begin errors++; $display("FAIL reset_r got=%h want=f", bif.r); end
    checks++; if (w_walk !== 1'b0) begin errors++; $display("FAIL reset_walk got=%b want=0", w_walk); end
  endtask

  task automatic test_rest_in_green();
    logic [3:0] want_q;
    for (int j = 1; j <= 60; j++) begin
      step();
      want_q = 4'(4 - ((j / 4) % 5));
      checks++; if (bif.LED !== 6'b100001) begin errors++; $display("FAIL rest_led j=%0d got=%b want=100001", j, bif.LED); end
      checks++; if (bif.q !== want_q) begin errors++; $display("FAIL rest_q j=%0d got=%h want=%h", j, bif.q, want_q); end
      checks++; if (bif.r !== 4'hF) begin errors++; $display("FAIL rest_r j=%0d got=%h want=f", j, bif.r); end
    end
  endtask

  task automatic test_car_pulse();
    int n_bgrn, n_ayel;
    n_bgrn = 0; n_ayel = 0;
    for (int i = 0; i < int'($urandom_range(0, 7)); i++) step();
    bif.car_b = 1'b1;
    step();
    bif.car_b = 1'b0;
    if (bif.LED == 6'b100010) n_ayel++;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bif.LED == 6'b001100) n_bgrn++;
      if (bif.LED == 6'b100010) n_ayel++;
      checks++; if (w_act !== exp_vec()) begin errors++; $display("FAIL car_pulse_model i=%0d got=%h want=%h", i, w_act, exp_vec()); end
    end
    checks++; if (n_bgrn != GB * TD) begin errors++; $display("FAIL car_pulse_bgrn_cycles got=%0d want=%0d", n_bgrn, GB * TD); end
    checks++; if (n_ayel != YT * TD) begin errors++; $display("FAIL car_pulse_ayel_cycles got=%0d want=%0d", n_ayel, YT * TD); end
    checks++; if (bif.LED !== 6'b100001) begin errors++; $display("FAIL car_pulse_return got=%b want=100001", bif.LED); end
  endtask

  task automatic test_same_cycle_req();
    int k;
    k = 0;
    while (!(m_ph == 0 && m_left == 0 && m_div == TD - 1) && k < 200) begin
      step(); k++;
    end
    checks++;
    if (k >= 200) begin
      errors++; $display("FAIL same_cycle_wait got=timeout want=expiry_cycle");
    end else begin
      bif.car_b = 1'b1;
      step();
      bif.car_b = 1'b0;
      checks++; if (bif.LED !== 6'b100010) begin errors++; $display("FAIL same_cycle_led got=%b want=100010", bif.LED); end
      checks++; if (bif.q !== 4'(YT - 1)) begin errors++; $display("FAIL same_cycle_q got=%h want=%h", bif.q, 4'(YT - 1)); end
    end
    for (int i = 0; i < 60; i++) begin
      step();
      checks++; if (w_act !== exp_vec()) begin errors++; $display("FAIL same_cycle_model i=%0d got=%h want=%h", i, w_act, exp_vec()); end
    end
  endtask

  task automatic test_hold_through_bgrn();
    bit seen;
    int k, n_grn;
    seen = 0; k = 0; n_grn = 0;
    bif.car_b = 1'b1;
    while (k < 300 && !(seen && m_ph != 3)) begin
      step(); k++;
      if (m_ph == 3) seen = 1;
      checks++; if (w_act !== exp_vec()) begin errors++; $display("FAIL hold_model k=%0d got=%h want=%h", k, w_act, exp_vec()); end
    end
    bif.car_b = 1'b0;
    k = 0;
    while (m_ph != 0 && k < 100) begin step(); k++; end
    for (int i = 0; i < 2 * GA * TD; i++) begin
      step();
      if (bif.LED == 6'b100001) n_grn++;
    end
    checks++; if (n_grn != 2 * GA * TD) begin errors++; $display("FAIL hold_rest_cycles got=%0d want=%0d", n_grn, 2 * GA * TD); end
  endtask

  task automatic test_reset_mid_phase();
    int k;
    k = 0;
    bif.car_b = 1'b1;
    step();
    bif.car_b = 1'b0;
    while (m_ph != 4 && k < 200) begin step(); k++; end
    checks++; if (bif.LED !== 6'b010100) begin errors++; $display("FAIL midrst_byel got=%b want=010100", bif.LED); end
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    resetSW = 1'b1;
    step();
    resetSW = 1'b0;
    checks++; if (bif.LED !== 6'b100001) begin errors++; $display("FAIL midrst_led got=%b want=100001", bif.LED); end
    checks++; if (bif.q !== 4'd4) begin errors++; $display("FAIL midrst_q got=%h want=4", bif.q); end
    checks++; if (bif.r !== 4'hF) begin errors++; $display("FAIL midrst_r got=%h want=f", bif.r); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (bif.q !== 4'd4) begin errors++; $display("FAIL midrst_hold_q i=%0d got=%h want=4", i, bif.q); end
    end
    step();
    checks++; if (bif.q !== 4'd3) begin errors++; $display("FAIL midrst_first_tick got=%h want=3", bif.q); end
  endtask

`ifdef PED_WALK_EN
  task automatic test_walk();
    int k, n_walk;
    k = 0; n_walk = 0;
    bif.car_b = 1'b1;
    step();
    bif.car_b = 1'b0;
    while (m_ph != 3 && k < 200) begin step(); k++; end
    bif.ped_req = 1'b1;
    step();
    bif.ped_req = 1'b0;
    k = 0;
    while (m_ph != 6 && k < 200) begin step(); k++; end
    while (m_ph == 6 && k < 400) begin
      n_walk++;
      checks++; if (w_walk !== 1'b1 || bif.LED !== 6'b100100) begin errors++; $display("FAIL walk_lamp got=%b/%b want=1/100100", w_walk, bif.LED); end
      step(); k++;
    end
    checks++; if (n_walk != WT * TD) begin errors++; $display("FAIL walk_cycles got=%0d want=%0d", n_walk, WT * TD); end
    checks++; if (w_walk !== 1'b0 || bif.LED !== 6'b100001) begin errors++; $display("FAIL walk_exit got=%b/%b want=0/100001", w_walk, bif.LED); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bif.car_b = ($urandom_range(0, 19) == 0);
      set_ped($urandom_range(0, 29) == 0);
      resetSW = ($urandom_range(0, 199) == 0);
      step();
      checks++; if (w_act !== exp_vec()) begin errors++; $display("FAIL random_model i=%0d got=%h want=%h", i, w_act, exp_vec()); end
    end
    bif.car_b = 1'b0;
    set_ped(1'b0);
    resetSW = 1'b0;
  endtask

  initial begin
    resetSW = 1'b1;
    bif.car_b = 1'b0;
    set_ped(1'b0);
    m_div = 0; m_ph = 0; m_left = GA - 1; m_latb = 0; m_latp = 0;
    #1;
    test_reset();
    test_rest_in_green();
    test_car_pulse();
    test_same_cycle_req();
    test_hold_through_bgrn();
    test_reset_mid_phase();
`ifdef PED_WALK_EN
    test_walk();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
